// File: rtl/carry_resolve_seq.sv
// Iterative carry-save to binary resolver: one half-adder row per clock until carries drain.
// Optional early exit when the carry vector is already zero: CARRY_RESOLVE_EARLY_EXIT_EN.
module carry_resolve_seq #(
  parameter  int unsigned N  = 3,
  localparam int unsigned W  = N + 2,
  localparam int unsigned IW = $clog2(N + 3)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_sum,
  input  logic [N-1:0]  in_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_value,
  output logic [IW-1:0] out_iters
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nx;
  logic [W-1:0]  s, s_nx;
  logic [W-1:0]  c, c_nx;
  logic [IW-1:0] cnt, cnt_nx;
  logic          in_ready_nx, out_valid_nx;

`ifndef CARRY_RESOLVE_EARLY_EXIT_EN
  localparam int unsigned SW = $clog2(W + 1);
  logic [SW-1:0] stp, stp_nx;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      c         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifndef CARRY_RESOLVE_EARLY_EXIT_EN
      stp       <= '0;
`endif
    end else begin
      state     <= state_nx;
      s         <= s_nx;
      c         <= c_nx;
      cnt       <= cnt_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
`ifndef CARRY_RESOLVE_EARLY_EXIT_EN
      stp       <= stp_nx;
`endif
    end
  end

  // Next-state and half-adder row
  always_comb begin
    state_nx = state;
    s_nx     = s;
    c_nx     = c;
    cnt_nx   = cnt;
`ifndef CARRY_RESOLVE_EARLY_EXIT_EN
    stp_nx   = stp;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          s_nx     = {2'b00, in_sum};
          c_nx     = {1'b0, in_carry, 1'b0};
          cnt_nx   = '0;
`ifndef CARRY_RESOLVE_EARLY_EXIT_EN
          stp_nx   = '0;
`endif
          state_nx = RUN;
        end
      end
      RUN: begin
`ifdef CARRY_RESOLVE_EARLY_EXIT_EN
        if (c == '0) begin
          state_nx = DONE;
        end else begin
          s_nx   = s ^ c;
          c_nx   = W'((s & c) << 1);
          cnt_nx = cnt + IW'(1);
        end
`else
        // Fixed latency: always W steps, counting only those with a live carry
        if (stp == SW'(W)) begin
          state_nx = DONE;
        end else begin
          s_nx   = s ^ c;
          c_nx   = W'((s & c) << 1);
          stp_nx = stp + SW'(1);
          if (c != '0) cnt_nx = cnt + IW'(1);
        end
`endif
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx  = (state_nx == IDLE);
    out_valid_nx = (state_nx == DONE);
  end

  assign out_value = s;
  assign out_iters = cnt;

endmodule

// File: tb/tb_carry_resolve_seq.sv
// Directed and exhaustive bench for carry_resolve_seq (N=3); honours CARRY_RESOLVE_EARLY_EXIT_EN.
module tb_carry_resolve_seq;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = N + 2;
  localparam int unsigned IW = $clog2(N + 3);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_sum;
  logic [N-1:0]  in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_value;
  logic [IW-1:0] out_iters;

  int n_checks = 0;
  int n_errors = 0;

  carry_resolve_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_iters (out_iters)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one operand and complete the accept edge; scramble inputs afterwards
  task automatic send(input logic [N-1:0] s, input logic [N-1:0] c);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("send_ready", int'(in_ready), 1);
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = N'($urandom);
    in_carry = N'($urandom);
  endtask

  // Cycles from the accept edge until out_valid is seen
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
    check("done_timeout", int'(out_valid), 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic int exp_lat(input int iters);
`ifdef CARRY_RESOLVE_EARLY_EXIT_EN
    return iters + 1;
`else
    return W + 1;
`endif
  endfunction

  // Directed vectors: sum, carry, expected value, expected iterations
  typedef struct { logic [N-1:0] s; logic [N-1:0] c; int val; int its; } vec_t;
  vec_t vecs [4] = '{
    '{3'b110, 3'b001, 8,  3},
    '{3'b111, 3'b000, 7,  0},
    '{3'b111, 3'b111, 21, 3},
    '{3'b000, 3'b000, 0,  0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int hold_val, hold_its;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_value", int'(out_value), 0);
    check("rst_out_iters", int'(out_iters), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].s, vecs[i].c);
      wait_done(lat);
      check($sformatf("dir%0d_value", i), int'(out_value), vecs[i].val);
      check($sformatf("dir%0d_iters", i), int'(out_iters), vecs[i].its);
      check($sformatf("dir%0d_lat", i), lat, exp_lat(vecs[i].its));
      check($sformatf("dir%0d_in_ready", i), int'(in_ready), 0);
      handshake();
    end

    // Back-pressure in DONE with an ignored in_valid
    send(3'b111, 3'b111);
    wait_done(lat);
    hold_val = 21;
    hold_its = 3;
    in_valid = 1'b1;
    in_sum   = 3'b001;
    in_carry = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", k), int'(out_valid), 1);
      check($sformatf("hold%0d_value", k), int'(out_value), hold_val);
      check($sformatf("hold%0d_iters", k), int'(out_iters), hold_its);
      check($sformatf("hold%0d_in_ready", k), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    handshake();
    check("release_in_ready",  int'(in_ready),  1);
    check("release_out_valid", int'(out_valid), 0);
    send(3'b011, 3'b010);
    wait_done(lat);
    check("after_hold_value", int'(out_value), 7);
    check("after_hold_iters", int'(out_iters), 1);
    check("after_hold_lat", lat, exp_lat(1));
    handshake();

    // Asynchronous reset mid-RUN, away from any clock edge
    send(3'b110, 3'b001);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", int'(out_valid), 0);
    check("midrun_out_value", int'(out_value), 0);
    check("midrun_out_iters", int'(out_iters), 0);
    check("midrun_in_ready",  int'(in_ready),  1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(3'b101, 3'b011);
    wait_done(lat);
    check("post_rst_value", int'(out_value), 11);
    check("post_rst_iters", int'(out_iters), 2);
    handshake();

    // Every operand pair
    for (int si = 0; si < 8; si++) begin
      for (int ci = 0; ci < 8; ci++) begin
        send(N'(si), N'(ci));
        wait_done(lat);
        check($sformatf("sweep_%0d_%0d_value", si, ci), int'(out_value), si + 2 * ci);
`ifdef CARRY_RESOLVE_EARLY_EXIT_EN
        check($sformatf("sweep_%0d_%0d_lat", si, ci), lat, int'(out_iters) + 1);
`else
        check($sformatf("sweep_%0d_%0d_lat", si, ci), lat, W + 1);
`endif
        check($sformatf("sweep_%0d_%0d_iters_le_w", si, ci), int'(out_iters <= IW'(W)), 1);
        handshake();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
